pong_game_logic: RTL
====================

# pong_game_logic

Frame-rate game-state engine for the Pong design; sits directly upstream of `pong_renderer` and drives its `ball_x`, `ball_y`, `paddleL_y` and `paddleR_y` inputs.
- Once per video frame it moves the paddles from button inputs and advances the ball.
- It resolves wall and paddle collisions, detects misses, keeps score and sequences serve, point and game-over.
- All outputs are registered and stay stable for a whole frame, so the renderer sees a consistent scene.

## Interface
- `SCREEN_W`, 640: active width in pixels
- `SCREEN_H`, 480: active height in pixels
- `BALL_SIZE`, 8: ball edge length
- `PADDLE_W`, 8: paddle width
- `PADDLE_H`, 64: paddle height
- `PADDLE_L_X`, 16: left paddle left edge
- `PADDLE_R_X`, 616: right paddle left edge
- `BALL_SPEED`, 4: ball step per frame, both axes
- `PADDLE_SPEED`, 4: paddle step per frame
- `POINT_FRAMES`, 60: freeze length after a miss
- `WIN_SCORE`, 9: score that ends the game
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `frame_tick` in 1: one-cycle pulse, once per frame, at the start of vertical blank
- `btn_l_up`, `btn_l_dn`, `btn_r_up`, `btn_r_dn` in 1 each: paddle controls, synchronous levels
- `serve` in 1: serve / restart request, level
- `ball_x`, `ball_y` out 10: ball top-left corner
- `paddleL_y`, `paddleR_y` out 10: paddle top edges
- `score_l`, `score_r` out 4: scores
- `game_over` out 1: high while in GAME_OVER

## Operation
State machine with four states: SERVE, PLAY, POINT, GAME_OVER. State changes only on cycles with `frame_tick` high. Inputs are sampled only on those cycles.

Paddles:
- In every state except GAME_OVER, each paddle moves by `PADDLE_SPEED` on each tick: up subtracts, down adds.
- Up and down held together means no move.
- Position is clamped to 0..`SCREEN_H`-`PADDLE_H` (0..416).

SERVE:
- Ball is held at centre (316, 236).
- On a tick with `serve`=1, go to PLAY. The ball does not move on that tick.
- Serve direction: vx points toward the player who lost the last point. The first serve after reset, or after GAME_OVER, goes to the right. vy is kept from the previous rally.

PLAY, on each tick:
- Compute nx = `ball_x`+vx and ny = `ball_y`+vy in 11-bit signed arithmetic.
- Wall bounce:
  - ny ≤ 0 sets y to 0 and vy to +.
  - ny ≥ `SCREEN_H`-`BALL_SIZE` sets y to 472 and vy to −.
- Left paddle hit. All of these must hold:
  - vx < 0;
  - nx ≤ 24 and the old `ball_x` ≥ 24;
  - vertical overlap between the ball and the pre-tick `paddleL_y`: `ball_y`+8 > `paddleL_y` and `ball_y` < `paddleL_y`+64.
  - Result: x = 24, vx becomes +.
- Right paddle hit is the mirror case: nx+8 ≥ 616 with the old `ball_x`+8 ≤ 616. Result: x = 608, vx becomes −.
- Left miss: nx ≤ 0 without a hit. x = 0, `score_r`+1, go to POINT.
- Right miss: nx ≥ 632. x = 632, `score_l`+1, go to POINT.
- A wall event and a paddle or miss event on the same tick are applied independently (corner case).

POINT:
- Ball is frozen.
- A frame counter runs to `POINT_FRAMES`.
- On the tick that completes the count:
  - if the scorer's score equals `WIN_SCORE`, go to GAME_OVER;
  - otherwise centre the ball and go to SERVE.

GAME_OVER:
- Paddles and ball are frozen.
- A tick with `serve`=1 clears both scores, centres the ball and paddles, and goes to SERVE.

Scores never exceed `WIN_SCORE`.

## Timing
Reset values:
- `ball_x` = 316, `ball_y` = 236
- `paddleL_y` = `paddleR_y` = 208
- both scores 0
- `game_over` = 0
- state SERVE, vx = +, vy = +, point counter 0

Latency:
- Every output updates on the clock edge that samples `frame_tick`=1, and is visible in the following cycle.
- Outputs hold otherwise, for a full frame.
- `frame_tick` held high for several cycles counts as several ticks. This is not legal stimulus.

Reset:
- `rst` asserted mid-frame or mid-POINT forces all reset values immediately, asynchronously.
- The first tick after `rst` is released is processed normally.

## Structure
- Geometry and speed constants and the state encodings go in shared `pong_defs.vh`. `pong_renderer` includes the same file, so geometry cannot diverge.
- One natural sub-module: `pong_paddle`, holding the position register, up/down logic and clamp. It is instantiated twice.
- The ball, collision logic, score and FSM stay in the top module.

## Test plan
- Reset: assert `rst` mid-run. Required: immediately 316/236/208/208, scores 0, `game_over` 0.
- Serve: `serve`=1 on a tick leaves the ball at 316,236. The next tick gives 320,240, then 324,244.
- Wall: ball at y=2 with vy=−4. Required: next tick y=0, the following tick y=4.
- Left hit: `paddleL_y`=208, ball at (28,230) moving left. Required: next tick `ball_x`=24, then 28.
- Miss: `paddleL_y`=0, ball at (4,300) moving left. Required: `ball_x`=0 and `score_r`=1. After 60 ticks the ball is at 316,236 in SERVE, and the next serve goes left.
- Clamp and end of game:
  - `btn_l_up` for 60 ticks gives `paddleL_y`=0; both buttons held leaves it unchanged.
  - Driving the ninth right miss asserts `game_over` after the POINT freeze.
  - `serve` then clears the scores.

Source files
------------

// File: rtl/pong_game_logic_pkg.sv
// Shared geometry, speeds and state encoding for the Pong game-state engine.
// The renderer imports the same package so scene geometry cannot diverge.
package pong_game_logic_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BALL_SIZE    = 8;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_L_X   = 16;
    localparam int PADDLE_R_X   = 616;
    localparam int BALL_SPEED   = 4;
    localparam int PADDLE_SPEED = 4;
    localparam int POINT_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    localparam int CNT_W = $clog2(POINT_FRAMES);

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_POINT     = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam logic [9:0] BALL_CX      = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_CY      = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0] PADDLE_CY    = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0] PADDLE_MAX_Y = 10'(SCREEN_H - PADDLE_H);

    // Ball-motion thresholds, signed so a step past the left/top edge compares correctly.
    localparam logic signed [10:0] BALL_STEP  = 11'(BALL_SPEED);
    localparam logic signed [10:0] BALL_MAX_Y = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] HIT_L_X    = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [10:0] HIT_R_X    = 11'(PADDLE_R_X - BALL_SIZE);
    localparam logic signed [10:0] MISS_R_X   = 11'(SCREEN_W - BALL_SIZE);

    function automatic logic overlaps(input logic [9:0] ball_top, input logic [9:0] pad_top);
        logic [10:0] b;
        logic [10:0] p;
        b = {1'b0, ball_top};
        p = {1'b0, pad_top};
        return (b + 11'(BALL_SIZE) > p) && (b < p + 11'(PADDLE_H));
    endfunction

endpackage

// File: rtl/pong_game_logic_paddle.sv
// One paddle: position register, up/down step per frame and clamp to the screen.
module pong_game_logic_paddle
    import pong_game_logic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       move_en,
    input  logic       center,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    localparam logic [9:0] STEP = 10'(PADDLE_SPEED);

    logic [9:0] y_d;

    always_comb begin
        y_d = y;
        if (center) begin
            y_d = PADDLE_CY;
        end else if (move_en && up && !dn) begin
            y_d = (y < STEP) ? 10'd0 : y - STEP;
        end else if (move_en && dn && !up) begin
            y_d = (y > PADDLE_MAX_Y - STEP) ? PADDLE_MAX_Y : y + STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= PADDLE_CY;
        end else begin
            y <= y_d;
        end
    end

endmodule

// File: rtl/pong_game_logic.sv
// Frame-rate Pong engine: ball motion, collisions, scoring and serve/point/game-over
// sequencing. Everything advances only on frame_tick; outputs hold for the whole frame.
module pong_game_logic
    import pong_game_logic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_l_up,
    input  logic        btn_l_dn,
    input  logic        btn_r_up,
    input  logic        btn_r_dn,
    input  logic        serve,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [9:0]  paddleL_y,
    output logic [9:0]  paddleR_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over,
    output game_state_t state_dbg
);

    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POINT_FRAMES - 1);

    game_state_t       state_q, state_d;
    logic [9:0]        ball_x_d, ball_y_d;
    logic              vx_pos, vx_pos_d, vy_pos, vy_pos_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              scorer_left_q, scorer_left_d;
    logic [3:0]        score_l_d, score_r_d;
    logic signed [10:0] nx, ny;
    logic              hit_l, hit_r;
    logic              paddle_en, paddle_center;

    assign state_dbg     = state_q;
    assign paddle_en     = frame_tick && (state_q != ST_GAME_OVER);
    assign paddle_center = frame_tick && (state_q == ST_GAME_OVER) && serve;

    pong_game_logic_paddle u_paddle_l (
        .clk     (clk),
        .rst     (rst),
        .move_en (paddle_en),
        .center  (paddle_center),
        .up      (btn_l_up),
        .dn      (btn_l_dn),
        .y       (paddleL_y)
    );

    pong_game_logic_paddle u_paddle_r (
        .clk     (clk),
        .rst     (rst),
        .move_en (paddle_en),
        .center  (paddle_center),
        .up      (btn_r_up),
        .dn      (btn_r_dn),
        .y       (paddleR_y)
    );

    // Collisions use the pre-tick paddle positions, which are the current register values.
    always_comb begin
        nx    = $signed({1'b0, ball_x}) + (vx_pos ? BALL_STEP : -BALL_STEP);
        ny    = $signed({1'b0, ball_y}) + (vy_pos ? BALL_STEP : -BALL_STEP);
        hit_l = !vx_pos && (nx <= HIT_L_X) && (ball_x >= HIT_L_X[9:0])
                && overlaps(ball_y, paddleL_y);
        hit_r = vx_pos && (nx >= HIT_R_X) && (ball_x <= HIT_R_X[9:0])
                && overlaps(ball_y, paddleR_y);
    end

    always_comb begin
        state_d       = state_q;
        ball_x_d      = ball_x;
        ball_y_d      = ball_y;
        vx_pos_d      = vx_pos;
        vy_pos_d      = vy_pos;
        cnt_d         = cnt_q;
        scorer_left_d = scorer_left_q;
        score_l_d     = score_l;
        score_r_d     = score_r;
        if (frame_tick) begin
            case (state_q)
                ST_SERVE: begin
                    if (serve) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (ny <= 11'sd0) begin
                        ball_y_d = 10'd0;
                        vy_pos_d = 1'b1;
                    end else if (ny >= BALL_MAX_Y) begin
                        ball_y_d = BALL_MAX_Y[9:0];
                        vy_pos_d = 1'b0;
                    end else begin
                        ball_y_d = ny[9:0];
                    end
                    // A miss also fixes the next serve direction: toward the player who lost.
                    if (hit_l) begin
                        ball_x_d = HIT_L_X[9:0];
                        vx_pos_d = 1'b1;
                    end else if (hit_r) begin
                        ball_x_d = HIT_R_X[9:0];
                        vx_pos_d = 1'b0;
                    end else if (nx <= 11'sd0) begin
                        ball_x_d      = 10'd0;
                        vx_pos_d      = 1'b0;
                        score_r_d     = (score_r == WIN) ? score_r : score_r + 4'd1;
                        scorer_left_d = 1'b0;
                        cnt_d         = '0;
                        state_d       = ST_POINT;
                    end else if (nx >= MISS_R_X) begin
                        ball_x_d      = MISS_R_X[9:0];
                        vx_pos_d      = 1'b1;
                        score_l_d     = (score_l == WIN) ? score_l : score_l + 4'd1;
                        scorer_left_d = 1'b1;
                        cnt_d         = '0;
                        state_d       = ST_POINT;
                    end else begin
                        ball_x_d = nx[9:0];
                    end
                end
                ST_POINT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if ((scorer_left_q ? score_l : score_r) == WIN) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            ball_x_d = BALL_CX;
                            ball_y_d = BALL_CY;
                            state_d  = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    if (serve) begin
                        score_l_d = 4'd0;
                        score_r_d = 4'd0;
                        ball_x_d  = BALL_CX;
                        ball_y_d  = BALL_CY;
                        vx_pos_d  = 1'b1;
                        state_d   = ST_SERVE;
                    end
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SERVE;
            ball_x        <= BALL_CX;
            ball_y        <= BALL_CY;
            vx_pos        <= 1'b1;
            vy_pos        <= 1'b1;
            cnt_q         <= '0;
            scorer_left_q <= 1'b0;
            score_l       <= 4'd0;
            score_r       <= 4'd0;
            game_over     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ball_x        <= ball_x_d;
            ball_y        <= ball_y_d;
            vx_pos        <= vx_pos_d;
            vy_pos        <= vy_pos_d;
            cnt_q         <= cnt_d;
            scorer_left_q <= scorer_left_d;
            score_l       <= score_l_d;
            score_r       <= score_r_d;
            game_over     <= (state_d == ST_GAME_OVER);
        end
    end

endmodule
